smm_job_arbiter: RTL and testbench

//  Shares one sparse-matrix-multiplier engine between two requesters, arbitrated round-robin.

---
 rtl/smm_job_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_smm_job_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/smm_job_arbiter.sv
// Round-robin arbiter sharing one SMM engine between two requesters: size strobe, A/B entry
// streaming, result routing and done/err reporting. Optional WAIT watchdog: SMM_ARB_WDOG_EN.
module smm_job_arbiter #(
  parameter int unsigned WDOG_CYCLES = 4095
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] req_size,
  output logic [1:0] grant,
  input  logic [1:0] ent_valid,
  input  logic [1:0] ent_mat,
  input  logic [1:0] ent_last,
  input  logic [9:0] ent_row,
  input  logic [9:0] ent_col,
  input  logic [7:0] ent_val,
  output logic [1:0] ent_ready,
  output logic       eng_valid_size,
  output logic       eng_size,
  output logic       eng_valid_a,
  output logic [4:0] eng_row_a,
  output logic [4:0] eng_col_a,
  output logic [3:0] eng_val_a,
  output logic       eng_valid_b,
  output logic [4:0] eng_row_b,
  output logic [4:0] eng_col_b,
  output logic [3:0] eng_val_b,
  input  logic       eng_out_valid,
  input  logic [4:0] eng_out_row,
  input  logic [4:0] eng_out_col,
  input  logic [8:0] eng_out_val,
  output logic [1:0] rsp_valid,
  output logic [4:0] rsp_row,
  output logic [4:0] rsp_col,
  output logic [8:0] rsp_val,
  output logic [1:0] rsp_done,
  output logic       rsp_err
);

  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_LOAD, S_WAIT, S_DRAIN, S_DONE} state_e;

  typedef struct packed {
    logic [4:0] row;
    logic [4:0] col;
    logic [3:0] val;
  } ent_t;

  typedef struct packed {
    logic [4:0] row;
    logic [4:0] col;
    logic [8:0] val;
  } rsp_t;

  state_e     state_q;
  logic       g_q, last_q, job_size_q, err_q, last_seen_q;
  logic [1:0] grant_q, ent_ready_q, rsp_valid_q, rsp_done_q;
  logic       evs_q, va_q, vb_q, rsp_err_q;
  ent_t       lane_a_q, lane_b_q;
  rsp_t       rsp_q;

  logic       win_d, acc_d, mat_d, last_d, rng_bad_d, eov_d;
  ent_t       ent_d;
  rsp_t       eng_out_d;

`ifdef SMM_ARB_WDOG_EN
  localparam int unsigned CNT_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WDOG_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q;
  logic             discard_q;
`endif

  always_comb begin
    // Tie goes to whoever was not served last; otherwise the lone requester wins.
    win_d     = (req == 2'b11) ? ~last_q : req[1];
    ent_d     = g_q ? {ent_row[9:5], ent_col[9:5], ent_val[7:4]}
                    : {ent_row[4:0], ent_col[4:0], ent_val[3:0]};
    acc_d     = ent_ready_q[g_q] & ent_valid[g_q];
    mat_d     = ent_mat[g_q];
    last_d    = ent_last[g_q];
    rng_bad_d = ~job_size_q & (ent_d.row[4] | ent_d.col[4]);
    eng_out_d = {eng_out_row, eng_out_col, eng_out_val};
`ifdef SMM_ARB_WDOG_EN
    eov_d     = eng_out_valid & ~discard_q;
`else
    eov_d     = eng_out_valid;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      g_q         <= 1'b0;
      last_q      <= 1'b1;
      job_size_q  <= 1'b0;
      err_q       <= 1'b0;
      last_seen_q <= 1'b0;
      grant_q     <= '0;
      ent_ready_q <= '0;
      evs_q       <= 1'b0;
      va_q        <= 1'b0;
      vb_q        <= 1'b0;
      lane_a_q    <= '0;
      lane_b_q    <= '0;
      rsp_valid_q <= '0;
      rsp_q       <= '0;
      rsp_done_q  <= '0;
      rsp_err_q   <= 1'b0;
`ifdef SMM_ARB_WDOG_EN
      cnt_q       <= '0;
      discard_q   <= 1'b0;
`endif
    end else begin
      evs_q       <= 1'b0;
      va_q        <= 1'b0;
      vb_q        <= 1'b0;
      rsp_valid_q <= '0;
      rsp_done_q  <= '0;
      rsp_err_q   <= 1'b0;
`ifdef SMM_ARB_WDOG_EN
      // A burst that begins outside WAIT/DRAIN is stale (post-abort) until it ends.
      discard_q   <= eng_out_valid &
                     (discard_q | (state_q != S_WAIT && state_q != S_DRAIN));
`endif
      unique case (state_q)
        S_IDLE: begin
          if (|req) begin
            g_q        <= win_d;
            grant_q    <= win_d ? 2'b10 : 2'b01;
            evs_q      <= 1'b1;
            job_size_q <= req_size[win_d];
            state_q    <= S_GRANT;
          end
        end
        S_GRANT: begin
          ent_ready_q <= grant_q;
          last_seen_q <= 1'b0;
          state_q     <= S_LOAD;
        end
        S_LOAD: begin
          if (acc_d) begin
            if (mat_d) begin
              vb_q     <= 1'b1;
              lane_b_q <= ent_d;
            end else begin
              va_q     <= 1'b1;
              lane_a_q <= ent_d;
            end
            if (rng_bad_d) err_q <= 1'b1;
            if (last_d) begin
              ent_ready_q <= '0;
              last_seen_q <= 1'b1;
            end
          end else if (ent_ready_q[g_q]) begin
            err_q <= 1'b1;
          end
          // Stay one extra cycle so the final entry's lane beat is still in LOAD.
          if (last_seen_q) begin
            state_q <= S_WAIT;
`ifdef SMM_ARB_WDOG_EN
            cnt_q   <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (eov_d) begin
            rsp_valid_q <= grant_q;
            rsp_q       <= eng_out_d;
            state_q     <= S_DRAIN;
`ifdef SMM_ARB_WDOG_EN
            cnt_q       <= '0;
          end else if (cnt_q == CNT_MAX) begin
            rsp_done_q  <= grant_q;
            rsp_err_q   <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            cnt_q       <= cnt_q + 1'b1;
`endif
          end
        end
        S_DRAIN: begin
          if (eov_d) begin
            rsp_valid_q <= grant_q;
            rsp_q       <= eng_out_d;
`ifdef SMM_ARB_WDOG_EN
            cnt_q       <= '0;
`endif
          end else begin
            rsp_done_q  <= grant_q;
            rsp_err_q   <= err_q;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          grant_q <= '0;
          err_q   <= 1'b0;
          last_q  <= g_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant          = grant_q;
  assign ent_ready      = ent_ready_q;
  assign eng_valid_size = evs_q;
  assign eng_size       = job_size_q;
  assign eng_valid_a    = va_q;
  assign eng_row_a      = lane_a_q.row;
  assign eng_col_a      = lane_a_q.col;
  assign eng_val_a      = lane_a_q.val;
  assign eng_valid_b    = vb_q;
  assign eng_row_b      = lane_b_q.row;
  assign eng_col_b      = lane_b_q.col;
  assign eng_val_b      = lane_b_q.val;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_row        = rsp_q.row;
  assign rsp_col        = rsp_q.col;
  assign rsp_val        = rsp_q.val;
  assign rsp_done       = rsp_done_q;
  assign rsp_err        = rsp_err_q;

endmodule

// File: tb/tb_smm_job_arbiter.sv
// Directed bench for smm_job_arbiter; define SMM_ARB_WDOG_EN to add the watchdog abort case.
module tb_smm_job_arbiter;

  logic       clk, rst_n;
  logic [1:0] req, req_size, grant_o;
  logic [1:0] ent_valid, ent_mat, ent_last, ent_ready_o;
  logic [9:0] ent_row, ent_col;
  logic [7:0] ent_val;
  logic       eng_valid_size_o, eng_size_o;
  logic       eng_valid_a_o, eng_valid_b_o;
  logic [4:0] eng_row_a_o, eng_col_a_o, eng_row_b_o, eng_col_b_o;
  logic [3:0] eng_val_a_o, eng_val_b_o;
  logic       eng_out_valid;
  logic [4:0] eng_out_row, eng_out_col;
  logic [8:0] eng_out_val;
  logic [1:0] rsp_valid_o, rsp_done_o;
  logic [4:0] rsp_row_o, rsp_col_o;
  logic [8:0] rsp_val_o;
  logic       rsp_err_o;
  logic [59:0] all_o;

  int n_vec  = 0;
  int n_miss = 0;

  smm_job_arbiter #(.WDOG_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req(req), .req_size(req_size), .grant(grant_o),
    .ent_valid(ent_valid), .ent_mat(ent_mat), .ent_last(ent_last),
    .ent_row(ent_row), .ent_col(ent_col), .ent_val(ent_val),
    .ent_ready(ent_ready_o),
    .eng_valid_size(eng_valid_size_o), .eng_size(eng_size_o),
    .eng_valid_a(eng_valid_a_o), .eng_row_a(eng_row_a_o),
    .eng_col_a(eng_col_a_o), .eng_val_a(eng_val_a_o),
    .eng_valid_b(eng_valid_b_o), .eng_row_b(eng_row_b_o),
    .eng_col_b(eng_col_b_o), .eng_val_b(eng_val_b_o),
    .eng_out_valid(eng_out_valid), .eng_out_row(eng_out_row),
    .eng_out_col(eng_out_col), .eng_out_val(eng_out_val),
    .rsp_valid(rsp_valid_o), .rsp_row(rsp_row_o), .rsp_col(rsp_col_o),
    .rsp_val(rsp_val_o), .rsp_done(rsp_done_o), .rsp_err(rsp_err_o)
  );

  assign all_o = {grant_o, ent_ready_o, eng_valid_size_o, eng_size_o,
                  eng_valid_a_o, eng_row_a_o, eng_col_a_o, eng_val_a_o,
                  eng_valid_b_o, eng_row_b_o, eng_col_b_o, eng_val_b_o,
                  rsp_valid_o, rsp_row_o, rsp_col_o, rsp_val_o, rsp_done_o, rsp_err_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: sim time limit reached, vectors=%0d", n_vec);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_ent(input int r, input bit v, input bit m, input bit l,
                         input logic [4:0] row, input logic [4:0] col, input logic [3:0] val);
    ent_valid[r]      = v;
    ent_mat[r]        = m;
    ent_last[r]       = l;
    ent_row[r*5 +: 5] = row;
    ent_col[r*5 +: 5] = col;
    ent_val[r*4 +: 4] = val;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0; req_size = '0;
    ent_valid = '0; ent_mat = '0; ent_last = '0;
    ent_row = '0; ent_col = '0; ent_val = '0;
    eng_out_valid = 1'b0; eng_out_row = '0; eng_out_col = '0; eng_out_val = '0;
    cyc(); cyc();
    chk("reset_outs", all_o, 60'd0);
    rst_n = 1'b1;
    cyc();
    chk("idle_outs", all_o, 60'd0);
  endtask

  // mode 0: normal job; 1: engine silent (watchdog); 2: reset asserted in DRAIN
  task automatic run_job(input int r, input bit sz, input logic [4:0] row, input logic [4:0] col,
                         input logic [3:0] val, input bit gap, input bit exp_err, input int mode);
    logic [1:0] oh;
    oh = (r == 1) ? 2'b10 : 2'b01;
    req[r] = 1'b1;
    req_size[r] = sz;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (grant_o != 2'b00) break;
    end
    chk("grant", grant_o, oh);
    chk("size_strobe", eng_valid_size_o, 1'b1);
    chk("eng_size", eng_size_o, sz);
    req[r] = 1'b0;
    set_ent(r, 1'b1, 1'b0, 1'b0, row, col, val);
    cyc();
    chk("ent_ready", ent_ready_o, oh);
    chk("strobe_once", eng_valid_size_o, 1'b0);
    cyc();
    chk("lane_a", {eng_valid_a_o, eng_valid_b_o, eng_row_a_o, eng_col_a_o, eng_val_a_o},
        {2'b10, row, col, val});
    if (gap) begin
      set_ent(r, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 4'd0);
      cyc();
      chk("gap_lanes", {eng_valid_a_o, eng_valid_b_o}, 2'b00);
    end
    set_ent(r, 1'b1, 1'b1, 1'b1, 5'd2, 5'd5, 4'd4);
    cyc();
    chk("lane_b", {eng_valid_a_o, eng_valid_b_o, eng_row_b_o, eng_col_b_o, eng_val_b_o},
        {2'b01, 5'd2, 5'd5, 4'd4});
    chk("ready_drop", ent_ready_o, 2'b00);
    set_ent(r, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 4'd0);
    cyc();
    chk("wait_lanes", {eng_valid_a_o, eng_valid_b_o}, 2'b00);
    if (mode == 1) begin
      for (int i = 0; i < 7; i++) begin
        cyc();
        chk("wdog_wait", rsp_done_o, 2'b00);
      end
      cyc();
      chk("wdog_done", {rsp_done_o, rsp_err_o}, {oh, 1'b1});
      return;
    end
    eng_out_valid = 1'b1; eng_out_row = 5'd1; eng_out_col = 5'd5; eng_out_val = 9'd12;
    cyc();
    chk("rsp", {rsp_valid_o, rsp_row_o, rsp_col_o, rsp_val_o}, {oh, 5'd1, 5'd5, 9'd12});
    if (mode == 2) begin
      #2 rst_n = 1'b0;
      #1 chk("async_rst", all_o, 60'd0);
      eng_out_valid = 1'b0;
      cyc();
      chk("rst_hold", all_o, 60'd0);
      rst_n = 1'b1;
      cyc();
      chk("post_rst", all_o, 60'd0);
      return;
    end
    eng_out_valid = 1'b0;
    cyc();
    chk("done", {rsp_valid_o, rsp_done_o, rsp_err_o}, {2'b00, oh, exp_err});
  endtask

  initial begin
    do_reset();
    // T1: r0 alone, clean job
    run_job(0, 1'b0, 5'd1, 5'd2, 4'd3, 1'b0, 1'b0, 0);
    cyc();
    chk("idle_after_done", {grant_o, rsp_done_o}, 4'b0000);
    // T3: r1, 16x16 with row 20 -> forwarded, error flagged
    run_job(1, 1'b0, 5'd20, 5'd3, 4'd7, 1'b0, 1'b1, 0);
    // 32x32 accepts row/col >= 16 without error
    run_job(0, 1'b1, 5'd20, 5'd17, 4'd9, 1'b0, 1'b0, 0);

    // T2: tie from reset -> r0, then alternate
    do_reset();
    req = 2'b11;
    run_job(0, 1'b0, 5'd3, 5'd4, 4'd1, 1'b0, 1'b0, 0);
    req[0] = 1'b1;
    run_job(1, 1'b0, 5'd6, 5'd7, 4'd2, 1'b0, 1'b0, 0);
    req[1] = 1'b1;
    // T4: r0 with a gap while r1 keeps requesting
    run_job(0, 1'b0, 5'd8, 5'd9, 4'd5, 1'b1, 1'b1, 0);
    run_job(1, 1'b0, 5'd10, 5'd11, 4'd6, 1'b0, 1'b0, 0);

`ifdef SMM_ARB_WDOG_EN
    // T5: silent engine aborts, pending r1 served next
    do_reset();
    run_job(0, 1'b0, 5'd1, 5'd1, 4'd1, 1'b0, 1'b1, 1);
    req[1] = 1'b1;
    run_job(1, 1'b0, 5'd2, 5'd3, 4'd4, 1'b0, 1'b0, 0);
`endif

    // T6: reset in DRAIN, then tie must go to r0 again
    run_job(1, 1'b0, 5'd4, 5'd4, 4'd4, 1'b0, 1'b0, 2);
    req = 2'b11;
    run_job(0, 1'b0, 5'd5, 5'd6, 4'd7, 1'b0, 1'b0, 0);
    run_job(1, 1'b0, 5'd7, 5'd8, 4'd9, 1'b0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
